// File: rtl/reg_file_shift_engine.sv
// Multi-ported register file with a serial shift engine that moves one bit per cycle
// from a source register into a destination register, reporting carry and zero flags.
module reg_file_shift_engine #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [WIDTH-1:0]   d_in,
    input  logic [ADDR_W-1:0]  rd_addr_a,
    input  logic [ADDR_W-1:0]  rd_addr_b,
    output logic [WIDTH-1:0]   d_out_a,
    output logic [WIDTH-1:0]   d_out_b,
    input  logic               start,
    input  logic [1:0]         shift_mode,
    input  logic [SHAMT_W-1:0] shift_amt,
    input  logic [ADDR_W-1:0]  src_addr,
    input  logic [ADDR_W-1:0]  dst_addr,
    output logic               busy,
    output logic               done,
    output logic               carry_out,
    output logic               zero,
    output logic [1:0]         fsm_state
);
    // Handshake: start is sampled only while idle; busy stays high from the accepting
    // edge through the write-back edge; done pulses for the single cycle after write-back.

    localparam int NREG = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_WB    = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   rf [NREG];
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] cnt;
    logic [1:0]         mode;
    logic [ADDR_W-1:0]  dst;
    logic               carry;
    logic [WIDTH-1:0]   next_work;
    logic               next_bit;

    assign d_out_a   = rf[rd_addr_a];
    assign d_out_b   = rf[rd_addr_b];
    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

    always_comb begin
        next_work = work;
        next_bit  = 1'b0;
        case (mode)
            2'b00: begin next_work = {work[WIDTH-2:0], 1'b0};       next_bit = work[WIDTH-1]; end
            2'b01: begin next_work = {1'b0, work[WIDTH-1:1]};       next_bit = work[0];       end
            2'b10: begin next_work = {work[WIDTH-1], work[WIDTH-1:1]}; next_bit = work[0];    end
            default: begin next_work = {work[0], work[WIDTH-1:1]};  next_bit = work[0];       end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
            state     <= S_IDLE;
            work      <= '0;
            cnt       <= '0;
            mode      <= 2'b00;
            dst       <= '0;
            carry     <= 1'b0;
            done      <= 1'b0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (wr) rf[wr_addr] <= d_in;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        work  <= rf[src_addr];
                        mode  <= shift_mode;
                        dst   <= dst_addr;
                        cnt   <= shift_amt;
                        carry <= 1'b0;
                        state <= (shift_amt != '0) ? S_SHIFT : S_WB;
                    end
                end
                S_SHIFT: begin
                    work  <= next_work;
                    carry <= next_bit;
                    cnt   <= cnt - 1'b1;
                    if (cnt == SHAMT_W'(1)) state <= S_WB;
                end
                S_WB: begin
                    // Placed after the external write so the shifter wins a collision on dst.
                    rf[dst]   <= work;
                    done      <= 1'b1;
                    carry_out <= carry;
                    zero      <= (work == '0);
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_file_shift_engine.sv
// Bench for reg_file_shift_engine: directed cases plus random operations checked
// against an arithmetic model of the register file and shift results.
module tb_reg_file_shift_engine;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr = 1'b0;
    logic [2:0]    wr_addr = '0;
    logic [W-1:0]  d_in = '0;
    logic [2:0]    rd_addr_a = '0;
    logic [2:0]    rd_addr_b = '0;
    logic [W-1:0]  d_out_a;
    logic [W-1:0]  d_out_b;
    logic          start = 1'b0;
    logic [1:0]    shift_mode = '0;
    logic [3:0]    shift_amt = '0;
    logic [2:0]    src_addr = '0;
    logic [2:0]    dst_addr = '0;
    logic          busy;
    logic          done;
    logic          carry_out;
    logic          zero;
    logic [1:0]    fsm_state;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [W-1:0]  rf_m [8];

    reg_file_shift_engine dut (
        .clk(clk), .reset(reset), .wr(wr), .wr_addr(wr_addr), .d_in(d_in),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .d_out_a(d_out_a), .d_out_b(d_out_b),
        .start(start), .shift_mode(shift_mode), .shift_amt(shift_amt),
        .src_addr(src_addr), .dst_addr(dst_addr), .busy(busy), .done(done),
        .carry_out(carry_out), .zero(zero), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Shift by amt in one step with plain operators; carry is the last bit pushed out.
    task automatic model_shift(input logic [1:0] m, input int amt, input logic [W-1:0] v,
                               output logic [W-1:0] r, output logic c);
        if (amt == 0) begin
            r = v; c = 1'b0;
        end else begin
            case (m)
                2'b00: begin r = v << amt;                      c = v[W-amt];   end
                2'b01: begin r = v >> amt;                      c = v[amt-1];   end
                2'b10: begin r = $signed(v) >>> amt;            c = v[amt-1];   end
                default: begin r = (v >> amt) | (v << (W-amt)); c = v[amt-1];   end
            endcase
        end
    endtask

    task automatic write_reg(input int a, input logic [W-1:0] d);
        wr = 1'b1; wr_addr = 3'(a); d_in = d;
        @(negedge clk);
        wr = 1'b0;
        rf_m[a] = d;
    endtask

    task automatic run_op(input logic [1:0] m, input int amt, input int src, input int dst,
                          input bit coll_en, input int coll_addr, input logic [W-1:0] coll_data,
                          input bit spur);
        logic [W-1:0] v, r;
        logic         c;
        int           n;
        bit           seen;
        v = rf_m[src];
        model_shift(m, amt, v, r, c);
        shift_mode = m; shift_amt = 4'(amt); src_addr = 3'(src); dst_addr = 3'(dst);
        rd_addr_a = 3'(dst);
        rd_addr_b = coll_en ? 3'(coll_addr) : 3'($urandom_range(0, 7));
        start = 1'b1;
        seen = 1'b0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            wr = 1'b0;
            if (done) begin seen = 1'b1; break; end
            check("busy_during_op", busy, 1'b1);
            if (spur && n == 2) begin
                start = 1'b1; shift_mode = 2'b00; shift_amt = 4'd1;
                src_addr = 3'((src + 1) % 8); dst_addr = 3'((dst + 2) % 8);
            end
            if (coll_en && n == amt + 1) begin
                wr = 1'b1; wr_addr = 3'(coll_addr); d_in = coll_data;
            end
        end
        wr = 1'b0;
        check("done_seen", seen, 1'b1);
        if (seen) begin
            if (coll_en && coll_addr != dst) rf_m[coll_addr] = coll_data;
            rf_m[dst] = r;
            check("latency", n, amt + 2);
            check("busy_in_done", busy, 1'b0);
            check("result", d_out_a, r);
            check("carry_out", carry_out, c);
            check("zero", zero, r == '0);
            check("port_b", d_out_b, rf_m[rd_addr_b]);
        end
    endtask

    task automatic idle_check(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            check("no_extra_done", done, 1'b0);
            check("idle_busy", busy, 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf_m[i] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
            #1;
            check("rst_rd_a", d_out_a, 16'h0000);
            check("rst_rd_b", d_out_b, 16'h0000);
        end
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_carry", carry_out, 1'b0);
        check("rst_zero", zero, 1'b0);
        @(negedge clk);

        write_reg(0, 16'h004B);
        run_op(2'b00, 1, 0, 0, 0, 0, '0, 0);
        check("lsl_r0", d_out_a, 16'h0096);
        write_reg(1, 16'h8001);
        run_op(2'b00, 1, 1, 1, 0, 0, '0, 0);
        check("lsl_r1", d_out_a, 16'h0002);
        check("lsl_r1_carry", carry_out, 1'b1);

        write_reg(1, 16'h8037);
        run_op(2'b10, 4, 1, 2, 0, 0, '0, 0);
        check("asr_r2", d_out_a, 16'hF803);
        check("asr_carry", carry_out, 1'b0);
        rd_addr_b = 3'd1; #1;
        check("asr_src_kept", d_out_b, 16'h8037);
        write_reg(4, 16'h0001);
        run_op(2'b11, 1, 4, 4, 0, 0, '0, 0);
        check("ror_res", d_out_a, 16'h8000);
        check("ror_carry", carry_out, 1'b1);
        write_reg(4, 16'h0001);
        run_op(2'b01, 1, 4, 4, 0, 0, '0, 0);
        check("lsr_zero", zero, 1'b1);
        check("lsr_carry", carry_out, 1'b1);

        write_reg(2, 16'h1234);
        run_op(2'b01, 0, 2, 3, 0, 0, '0, 0);
        check("amt0_r3", d_out_a, 16'h1234);
        check("amt0_carry", carry_out, 1'b0);

        write_reg(1, 16'h8037);
        run_op(2'b10, 4, 1, 5, 1, 5, 16'hAAAA, 1);
        check("coll_dst", d_out_a, 16'hF803);
        idle_check(6);
        run_op(2'b10, 4, 1, 5, 1, 6, 16'h5555, 1);
        check("coll_other", d_out_b, 16'h5555);
        idle_check(6);

        // Back-to-back: second start issued in the done cycle of the first.
        write_reg(3, 16'h0F0F);
        run_op(2'b00, 2, 3, 3, 0, 0, '0, 0);
        run_op(2'b00, 2, 3, 3, 0, 0, '0, 0);
        check("b2b_res", d_out_a, 16'hF0F0);
        @(negedge clk);

        write_reg(7, 16'h00FF);
        shift_mode = 2'b00; shift_amt = 4'd8; src_addr = 3'd7; dst_addr = 3'd6;
        rd_addr_a = 3'd6;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) rf_m[i] = '0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_dst", d_out_a, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        idle_check(12);
        rd_addr_a = 3'd6; #1;
        check("abort_no_wb", d_out_a, 16'h0000);
        write_reg(7, 16'h00FF);
        run_op(2'b00, 8, 7, 6, 0, 0, '0, 0);
        check("post_reset_op", d_out_a, 16'hFF00);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 2) == 0)
                write_reg($urandom_range(0, 7), 16'($urandom()));
            run_op(2'($urandom_range(0, 3)), $urandom_range(0, W-1),
                   $urandom_range(0, 7), $urandom_range(0, 7),
                   1'($urandom_range(0, 1)), $urandom_range(0, 7), 16'($urandom()), 0);
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
